hct74157_timed: RTL and testbench
=================================

# hct74157_timed

Cycle-level timing model of a 74HCT157 quad 2-to-1 data selector with active-low enable. It selects I0 or I1 onto a 4-bit output and forces the output to zero when disabled. Every input path reaches Y after its own fixed propagation delay, expressed in clock cycles; at 1 cycle = 1 ns it reproduces the datasheet delays. It sits in the simulation library as a drop-in for glue-logic multiplexers where data-path timing is verified.

## Interface
- E_PD, 12, enable-to-output delay in cycles (1..64)
- I_PD, 13, data (I0/I1)-to-output delay in cycles (1..64)
- S_PD, 20, select-to-output delay in cycles (1..64)
- clk  input  1  clock; every pipeline stage advances on the rising edge
- reset  input  1  synchronous, active-high reset
- I0  input  4  data selected when S=0
- I1  input  4  data selected when S=1
- S  input  1  select
- _E  input  1  active-low enable; 1 forces Y to 0000
- Y  output  4  delayed mux output

## Operation
- Four independent transport-delay lines (shift registers):
  - _E through E_PD stages.
  - S through S_PD stages.
  - I0 through I_PD stages.
  - I1 through I_PD stages.
- Each line samples its input on the rising edge and shifts one stage per edge.
- Y is combinational from the last stage of each line: Y = Ed ? 4'b0000 : (Sd ? I1d : I0d).
  - Ed, Sd, I0d and I1d are the line outputs.
  - There is no register between the line outputs and Y.
- Transport semantics:
  - Every input value, including a pulse only one cycle wide, reappears exactly once, delayed by its path.
  - No inertial filtering.
- Paths are not cross-coupled.
  - A select change and a data change made in the same cycle reach Y at their own delays.
  - Y may show intermediate mixes during that window. This is required behaviour.
- Disabled dominates: while Ed=1, Y=0000 regardless of Sd, I0d, I1d, including unknown data.
- Unknown (x) inputs propagate as x through the data and select lines.
  - An unknown data value reaches Y only when it is selected and enabled.
- Reset, synchronous at the rising edge while reset=1:
  - All _E stages load 1.
  - All S stages load 0.
  - All I0/I1 stages load 0000.
  - Y becomes 0000 in the cycle after the reset edge and stays 0000 while reset is held.
  - Reset mid-operation discards all in-flight values.
- After reset is released, inputs enter the lines on the next edge; no stale pre-reset value is ever emitted.

## Timing
- Sample edge k: the first rising edge at which a changed input is sampled.
- Y reflects that change after edge k + PD − 1, i.e. PD edges after the change including the sampling edge.
- Y holds the old value through edge k + PD − 2.
- With defaults:
  - _E 0→1: Y = 0000 after 12 edges.
  - Data change with enable already active: new data visible after 13 edges.
  - S change: old selection still on Y after 19 edges; new selection after 20.
- Enable and new data applied in the same cycle:
  - Y is 0000 until edge 12.
  - From edge 12 Y shows the old pipelined data (line contents); from edge 13 it shows the new data. With I_PD > E_PD the later path, data, governs.
- Throughput: one new value per cycle on every path; latency is fixed and independent of history.
- Reset has a one-edge effect; reset deasserted at edge r means inputs at edge r+1 are the first to propagate.

## Test plan
- Reset, then _E=1, S=1, I0=I1=x:
  - Y = 0000 immediately after reset.
  - Y = 0000 at every later cycle; x never appears.
- Enable path: hold _E=1 with I1=0101, S=1 settled, then set _E=0.
  - Y = 0000 after 11 edges.
  - Y = 0101 after 12 edges.
- Simultaneous enable and data: from a disabled, settled state, apply I0=1010, I1=0101, S=1, _E=0 together.
  - Y = 0101 after 13 edges and stays.
- Select flip from that state, S 1→0:
  - Y = 0101 after 19 edges.
  - Y = 1010 after 20 edges.
- One-cycle pulse: I1 goes 0000→1111→0000 for a single cycle while enabled with S=1.
  - Y = 1111 for exactly one cycle, 13 edges later.
- Reset mid-flight: change S, then assert reset for one edge 5 cycles later.
  - Y = 0000 the next cycle.
  - The pending select change never appears.
  - Post-reset inputs propagate with nominal delays.

Source files
------------

// File: rtl/hct74157_timed_if.sv
// Pin bundle of the 74HCT157 timing model: four select/enable/data inputs and the muxed output.
// The master side drives the inputs; the slave (the model itself) drives Y.
interface hct74157_timed_if;
   logic [3:0] I0;
   logic [3:0] I1;
   logic       S;
   logic       _E;
   logic [3:0] Y;

   modport master (
      output I0,
      output I1,
      output S,
      output _E,
      input  Y
   );

   modport slave (
      input  I0,
      input  I1,
      input  S,
      input  _E,
      output Y
   );
endinterface

// File: rtl/hct74157_timed.sv
// Cycle-level 74HCT157: each input path is a transport delay line of its own length,
// and Y is a purely combinational mux of the line outputs.
module hct74157_timed #(
   parameter int E_PD = 12,
   parameter int I_PD = 13,
   parameter int S_PD = 20
) (
   input  logic               clk,
   input  logic               reset,
   hct74157_timed_if.slave    bus
);

   // I0 and I1 share a path delay, so they travel together as {I1, I0}.
   logic       e_reg [E_PD];
   logic       s_reg [S_PD];
   logic [7:0] d_reg [I_PD];

   genvar gi;
   generate
      for (gi = 0; gi < E_PD; gi++) begin : g_e
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (reset) e_reg[gi] <= 1'b1;
               else       e_reg[gi] <= bus._E;
            end
         end else begin : g_body
            always_ff @(posedge clk) begin
               if (reset) e_reg[gi] <= 1'b1;
               else       e_reg[gi] <= e_reg[gi-1];
            end
         end
      end

      for (gi = 0; gi < S_PD; gi++) begin : g_s
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (reset) s_reg[gi] <= 1'b0;
               else       s_reg[gi] <= bus.S;
            end
         end else begin : g_body
            always_ff @(posedge clk) begin
               if (reset) s_reg[gi] <= 1'b0;
               else       s_reg[gi] <= s_reg[gi-1];
            end
         end
      end

      for (gi = 0; gi < I_PD; gi++) begin : g_d
         if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (reset) d_reg[gi] <= 8'h00;
               else       d_reg[gi] <= {bus.I1, bus.I0};
            end
         end else begin : g_body
            always_ff @(posedge clk) begin
               if (reset) d_reg[gi] <= 8'h00;
               else       d_reg[gi] <= d_reg[gi-1];
            end
         end
      end
   endgenerate

   logic       ed;
   logic       sd;
   logic [3:0] i0d;
   logic [3:0] i1d;

   assign ed  = e_reg[E_PD-1];
   assign sd  = s_reg[S_PD-1];
   assign i0d = d_reg[I_PD-1][3:0];
   assign i1d = d_reg[I_PD-1][7:4];

   // The ternary keeps disabled dominant even when the data or select lines carry x.
   assign bus.Y = ed ? 4'b0000 : (sd ? i1d : i0d);

endmodule

// File: tb/tb_hct74157_timed.sv
// Bench for hct74157_timed: a table of datasheet scenarios, hand-written corner sequences,
// and random traffic, all cross-checked every cycle against an input-history reference model.
module tb_hct74157_timed;
   localparam int E_PD = 12;
   localparam int I_PD = 13;
   localparam int S_PD = 20;
   localparam int HMAX = 4096;

   logic clk;
   logic reset;
   hct74157_timed_if bus ();

   hct74157_timed #(.E_PD(E_PD), .I_PD(I_PD), .S_PD(S_PD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       e;
      logic       s;
      logic [3:0] i0;
      logic [3:0] i1;
   } samp_t;

   typedef struct {
      int         cycles;
      logic       rst;
      logic       e;
      logic       s;
      logic [3:0] i0;
      logic [3:0] i1;
      logic [3:0] exp;
      string      name;
   } row_t;

   samp_t hist [HMAX];
   int    nedge;
   int    checks;
   int    errors;
   row_t  vec [$];

   // A path is flushed when the value that should now be leaving it was overwritten by a reset
   // somewhere inside its delay window, or predates the first reset.
   function automatic bit flushed(int n, int pd);
      if (n - pd + 1 < 0) return 1'b1;
      for (int k = n - pd + 1; k <= n; k++)
         if (hist[k].rst) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] model_y(int n);
      logic       ed;
      logic       sd;
      logic [3:0] a0;
      logic [3:0] a1;
      ed = flushed(n, E_PD) ? 1'b1 : hist[n-E_PD+1].e;
      sd = flushed(n, S_PD) ? 1'b0 : hist[n-S_PD+1].s;
      a0 = flushed(n, I_PD) ? 4'b0000 : hist[n-I_PD+1].i0;
      a1 = flushed(n, I_PD) ? 4'b0000 : hist[n-I_PD+1].i1;
      return ed ? 4'b0000 : (sd ? a1 : a0);
   endfunction

   task automatic drive(input logic r, input logic e, input logic s,
                        input logic [3:0] i0, input logic [3:0] i1);
      reset  = r;
      bus._E = e;
      bus.S  = s;
      bus.I0 = i0;
      bus.I1 = i1;
   endtask

   task automatic check(input string name, input logic [3:0] exp);
      checks++;
      if (bus.Y !== exp) begin
         errors++;
         $display("FAIL %s edge=%0d y=%b expected=%b", name, nedge - 1, bus.Y, exp);
      end
   endtask

   // One clock: record what the DUT samples, then compare Y against the model mid-cycle.
   task automatic tick();
      @(posedge clk);
      if (nedge >= HMAX) begin
         $display("FAIL history_overflow edge=%0d y=%b expected=%b", nedge, bus.Y, 4'b0000);
         $fatal(1, "history exhausted");
      end
      hist[nedge].rst = reset;
      hist[nedge].e   = bus._E;
      hist[nedge].s   = bus.S;
      hist[nedge].i0  = bus.I0;
      hist[nedge].i1  = bus.I1;
      nedge++;
      @(negedge clk);
      check("model", model_y(nedge - 1));
   endtask

   task automatic add_row(input int c, input logic r, input logic e, input logic s,
                          input logic [3:0] i0, input logic [3:0] i1,
                          input logic [3:0] exp, input string name);
      row_t x;
      x.cycles = c; x.rst = r; x.e = e; x.s = s;
      x.i0 = i0; x.i1 = i1; x.exp = exp; x.name = name;
      vec.push_back(x);
   endtask

   initial begin
      int hits;
      int first_hit;
      int stale;
      nedge  = 0;
      checks = 0;
      errors = 0;
      drive(1'b1, 1'b1, 1'b1, 4'bxxxx, 4'bxxxx);

      add_row( 1, 1, 1, 1, 4'bxxxx, 4'bxxxx, 4'b0000, "reset_y");
      add_row(30, 0, 1, 1, 4'bxxxx, 4'bxxxx, 4'b0000, "x_disabled");
      add_row(25, 0, 1, 1, 4'b0000, 4'b0101, 4'b0000, "settle_disabled");
      add_row(11, 0, 0, 1, 4'b0000, 4'b0101, 4'b0000, "enable_11");
      add_row( 1, 0, 0, 1, 4'b0000, 4'b0101, 4'b0101, "enable_12");
      add_row(25, 0, 1, 1, 4'b0000, 4'b0000, 4'b0000, "redisable");
      add_row(12, 0, 0, 1, 4'b1010, 4'b0101, 4'b0000, "simul_12");
      add_row( 1, 0, 0, 1, 4'b1010, 4'b0101, 4'b0101, "simul_13");
      add_row(10, 0, 0, 1, 4'b1010, 4'b0101, 4'b0101, "simul_hold");
      add_row(19, 0, 0, 0, 4'b1010, 4'b0101, 4'b0101, "select_19");
      add_row( 1, 0, 0, 0, 4'b1010, 4'b0101, 4'b1010, "select_20");

      foreach (vec[r]) begin
         drive(vec[r].rst, vec[r].e, vec[r].s, vec[r].i0, vec[r].i1);
         for (int c = 0; c < vec[r].cycles; c++) tick();
         check(vec[r].name, vec[r].exp);
         $display("row %0d %s cycles=%0d y=%b", r, vec[r].name, vec[r].cycles, bus.Y);
      end

      // Reset five cycles after a select change: the change must be discarded.
      drive(1'b0, 1'b0, 1'b1, 4'b1010, 4'b0101);
      for (int c = 0; c < 5; c++) tick();
      drive(1'b1, 1'b0, 1'b1, 4'b1010, 4'b0101);
      tick();
      check("reset_midflight", 4'b0000);
      drive(1'b0, 1'b0, 1'b0, 4'b1010, 4'b0101);
      stale = 0;
      for (int t = 1; t <= 30; t++) begin
         tick();
         if (bus.Y === 4'b0101) stale++;
         if (t == 11) check("post_reset_11", 4'b0000);
         if (t == 13) check("post_reset_13", 4'b1010);
      end
      checks++;
      if (stale != 0) begin
         errors++;
         $display("FAIL stale_select count=%0d expected=0", stale);
      end
      drive(1'b0, 1'b0, 1'b1, 4'b1010, 4'b0101);
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (t == 19) check("post_reset_sel_19", 4'b1010);
      end
      check("post_reset_sel_20", 4'b0101);
      $display("seq reset_midflight stale=%0d y=%b", stale, bus.Y);

      // Single-cycle pulse on I1 must appear exactly once, 13 edges later.
      drive(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
      for (int c = 0; c < 25; c++) tick();
      drive(1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111);
      hits = 0;
      first_hit = -1;
      for (int t = 1; t <= 30; t++) begin
         tick();
         if (t == 1) drive(1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
         if (bus.Y === 4'b1111) begin
            hits++;
            if (first_hit < 0) first_hit = t;
         end
      end
      checks++;
      if (hits != 1 || first_hit != 13) begin
         errors++;
         $display("FAIL pulse hits=%0d at=%0d expected hits=1 at=13", hits, first_hit);
      end
      $display("seq pulse hits=%0d at=%0d", hits, first_hit);

      // Random traffic with occasional resets, checked by the model on every edge.
      for (int blk = 0; blk < 8; blk++) begin
         for (int c = 0; c < 50; c++) begin
            drive(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom), 4'($urandom), 4'($urandom));
            tick();
         end
         $display("random block %0d edge=%0d y=%b errors=%0d", blk, nedge - 1, bus.Y, errors);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
